// File: rtl/ats21_pkg.sv
// Shared types and constants for the ATS21 instruction issuer.
package ats21_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        HI,
        LO,
        GAP1,
        GAP2
    } issue_state_t;

    localparam logic [2:0] OP_NOP       = 3'b000;
    localparam logic [2:0] OP_SET_CLK   = 3'b001;
    localparam logic [2:0] OP_EN_CLK    = 3'b010;
    localparam logic [2:0] OP_MODE      = 3'b011;
    localparam logic [2:0] OP_SET_ALARM = 3'b101;
    localparam logic [2:0] OP_SET_TIMER = 3'b110;
    localparam logic [2:0] OP_EN_ALARM  = 3'b111;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

endpackage

// File: rtl/ats21_instr_fifo.sv
// Single-clock 32-bit instruction FIFO; head is visible on dout while not empty.
module ats21_instr_fifo
    import ats21_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        push,
    input  logic        pop,
    input  logic [31:0] din,
    output logic [31:0] dout,
    output logic        full,
    output logic        empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    // A full FIFO refuses pushes even when a pop frees a slot on the same edge.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ats21_issue.sv
// Serialises instructions from clients A and B onto the ATS21 command port,
// one shared slot (req, high half, low half, two-cycle gap) at a time.
module ats21_issue
    import ats21_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        a_valid,
    input  logic [31:0] a_instr,
    output logic        a_ready,
    input  logic        b_valid,
    input  logic [31:0] b_instr,
    output logic        b_ready,
    input  logic        ats_ready,
    output logic        req,
    output logic [15:0] ctrlA,
    output logic [15:0] ctrlB,
    output logic        busy,
    output logic [15:0] slot_cnt
);

    issue_state_t state;
    issue_state_t state_next;

    logic [31:0] a_dout;
    logic [31:0] b_dout;
    logic        a_full;
    logic        b_full;
    logic        a_empty;
    logic        b_empty;
    logic        start;
    logic [31:0] hold_a;
    logic [31:0] hold_b;
    logic        req_q;
    logic [15:0] ctrl_a_q;
    logic [15:0] ctrl_b_q;
    logic [15:0] slot_cnt_q;

    assign start = (state == IDLE) && ats_ready && (!a_empty || !b_empty);

    ats21_instr_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo_a (
        .clk   (clk),
        .reset (reset),
        .push  (a_valid),
        .pop   (start),
        .din   (a_instr),
        .dout  (a_dout),
        .full  (a_full),
        .empty (a_empty)
    );

    ats21_instr_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo_b (
        .clk   (clk),
        .reset (reset),
        .push  (b_valid),
        .pop   (start),
        .din   (b_instr),
        .dout  (b_dout),
        .full  (b_full),
        .empty (b_empty)
    );

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = start ? REQ : IDLE;
            REQ:     state_next = HI;
            HI:      state_next = LO;
            LO:      state_next = GAP1;
            GAP1:    state_next = GAP2;
            GAP2:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            hold_a     <= NOP_INSTR;
            hold_b     <= NOP_INSTR;
            req_q      <= 1'b0;
            ctrl_a_q   <= '0;
            ctrl_b_q   <= '0;
            slot_cnt_q <= '0;
        end else begin
            state <= state_next;
            if (start) begin
                hold_a     <= a_empty ? NOP_INSTR : a_dout;
                hold_b     <= b_empty ? NOP_INSTR : b_dout;
                slot_cnt_q <= slot_cnt_q + 16'd1;
            end
            req_q <= (state_next == REQ);
            case (state_next)
                HI: begin
                    ctrl_a_q <= hold_a[31:16];
                    ctrl_b_q <= hold_b[31:16];
                end
                LO: begin
                    ctrl_a_q <= hold_a[15:0];
                    ctrl_b_q <= hold_b[15:0];
                end
                default: begin
                    ctrl_a_q <= '0;
                    ctrl_b_q <= '0;
                end
            endcase
        end
    end

    assign a_ready  = !a_full;
    assign b_ready  = !b_full;
    assign req      = req_q;
    assign ctrlA    = ctrl_a_q;
    assign ctrlB    = ctrl_b_q;
    assign busy     = (state != IDLE);
    assign slot_cnt = slot_cnt_q;

endmodule

// File: tb/tb_ats21_issue.sv
// Directed bench for ats21_issue with a per-client queue model as scoreboard.
module tb_ats21_issue;
    import ats21_pkg::*;

    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        a_valid;
    logic [31:0] a_instr;
    logic        a_ready;
    logic        b_valid;
    logic [31:0] b_instr;
    logic        b_ready;
    logic        ats_ready;
    logic        req;
    logic [15:0] ctrlA;
    logic [15:0] ctrlB;
    logic        busy;
    logic [15:0] slot_cnt;

    int          total = 0;
    int          bad = 0;
    int          cyc_n = 0;
    int          phase = 0;
    logic [31:0] qa[$];
    logic [31:0] qb[$];
    int          req_times[$];
    logic [31:0] cur_a;
    logic [31:0] cur_b;
    logic [15:0] exp_slot = '0;

    always #5 clk = ~clk;

    ats21_issue #(.FIFO_DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .a_valid   (a_valid),
        .a_instr   (a_instr),
        .a_ready   (a_ready),
        .b_valid   (b_valid),
        .b_instr   (b_instr),
        .b_ready   (b_ready),
        .ats_ready (ats_ready),
        .req       (req),
        .ctrlA     (ctrlA),
        .ctrlB     (ctrlB),
        .busy      (busy),
        .slot_cnt  (slot_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // One clock: check ready flags, cross the edge, then score outputs at the falling edge.
    task automatic cyc();
        logic        acc_a;
        logic        acc_b;
        logic [31:0] ia;
        logic [31:0] ib;
        chk("a_ready", {31'b0, a_ready}, 32'(qa.size() < DEPTH));
        chk("b_ready", {31'b0, b_ready}, 32'(qb.size() < DEPTH));
        acc_a = a_valid && a_ready;
        acc_b = b_valid && b_ready;
        ia = a_instr;
        ib = b_instr;
        @(posedge clk);
        @(negedge clk);
        cyc_n++;
        case (phase)
            0: begin
                chk("idle_ctrlA", {16'b0, ctrlA}, 0);
                chk("idle_ctrlB", {16'b0, ctrlB}, 0);
                if (req) begin
                    chk("req_has_work", 32'((qa.size() + qb.size()) != 0), 1);
                    cur_a = (qa.size() != 0) ? qa.pop_front() : NOP_INSTR;
                    cur_b = (qb.size() != 0) ? qb.pop_front() : NOP_INSTR;
                    exp_slot = exp_slot + 16'd1;
                    req_times.push_back(cyc_n);
                    chk("slot_cnt", {16'b0, slot_cnt}, {16'b0, exp_slot});
                    phase = 1;
                end
            end
            1: begin
                chk("hi_ctrlA", {16'b0, ctrlA}, {16'b0, cur_a[31:16]});
                chk("hi_ctrlB", {16'b0, ctrlB}, {16'b0, cur_b[31:16]});
                chk("hi_req", {31'b0, req}, 0);
                phase = 2;
            end
            default: begin
                chk("lo_ctrlA", {16'b0, ctrlA}, {16'b0, cur_a[15:0]});
                chk("lo_ctrlB", {16'b0, ctrlB}, {16'b0, cur_b[15:0]});
                chk("lo_req", {31'b0, req}, 0);
                phase = 0;
            end
        endcase
        if (acc_a) qa.push_back(ia);
        if (acc_b) qb.push_back(ib);
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        a_valid = 1'b0;
        b_valid = 1'b0;
        repeat (n) @(negedge clk);
        qa.delete();
        qb.delete();
        phase = 0;
        exp_slot = '0;
        reset = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while ((busy || phase != 0 || qa.size() != 0 || qb.size() != 0) && n < budget) begin
            cyc();
            n++;
        end
        chk("drained", 32'(qa.size() + qb.size()), 0);
        chk("idle", {31'b0, busy}, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        a_valid = 1'b0;
        b_valid = 1'b0;
        a_instr = '0;
        b_instr = '0;
        ats_ready = 1'b0;
        repeat (4) @(negedge clk);
        chk("rst_req", {31'b0, req}, 0);
        chk("rst_ctrlA", {16'b0, ctrlA}, 0);
        chk("rst_ctrlB", {16'b0, ctrlB}, 0);
        chk("rst_busy", {31'b0, busy}, 0);
        chk("rst_slot", {16'b0, slot_cnt}, 0);
        chk("rst_a_ready", {31'b0, a_ready}, 1);
        chk("rst_b_ready", {31'b0, b_ready}, 1);
        reset = 1'b0;

        // Single A instruction, B idle: exact slot timing.
        ats_ready = 1'b1;
        a_valid = 1'b1;
        a_instr = 32'h2000_0000;
        cyc();
        a_valid = 1'b0;
        chk("t1_req_k", {31'b0, req}, 0);
        cyc();
        chk("t1_req_k1", {31'b0, req}, 1);
        chk("t1_busy", {31'b0, busy}, 1);
        repeat (4) cyc();
        chk("t1_busy_gap2", {31'b0, busy}, 1);
        cyc();
        chk("t1_idle", {31'b0, busy}, 0);
        chk("t1_slot", {16'b0, slot_cnt}, 1);

        // Both clients in the same cycle share one slot.
        a_valid = 1'b1;
        b_valid = 1'b1;
        a_instr = 32'h2040_0000;
        b_instr = 32'h2240_0000;
        cyc();
        a_valid = 1'b0;
        b_valid = 1'b0;
        wait_idle(20);
        chk("t2_slot", {16'b0, slot_cnt}, 2);

        // Stall with ats_ready low: fill A, fifth push refused.
        ats_ready = 1'b0;
        a_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            a_instr = 32'h3000_0000 + 32'(i * 32'h0001_0001);
            if (i == 4) chk("t3_full", {31'b0, a_ready}, 0);
            cyc();
        end
        a_valid = 1'b0;
        repeat (3) begin
            cyc();
            chk("t3_stall_req", {31'b0, req}, 0);
        end
        req_times.delete();
        ats_ready = 1'b1;
        wait_idle(60);
        chk("t3_nslots", 32'(req_times.size()), 4);
        for (int i = 1; i < 4; i++) begin
            if (i < req_times.size())
                chk("t3_spacing", 32'(req_times[i] - req_times[i-1]), 6);
        end

        // Full FIFO popped on the start edge; held push accepted exactly once.
        ats_ready = 1'b0;
        a_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a_instr = 32'h5000_0000 + 32'(i);
            cyc();
        end
        chk("t4_full", {31'b0, a_ready}, 0);
        a_instr = 32'h5000_0009;
        ats_ready = 1'b1;
        cyc();
        chk("t4_ready_after_pop", {31'b0, a_ready}, 1);
        cyc();
        a_valid = 1'b0;
        wait_idle(80);
        repeat (8) cyc();
        chk("t4_no_extra", {16'b0, slot_cnt}, {16'b0, exp_slot});

        // Reset asserted while the slot is in HI.
        a_valid = 1'b1;
        a_instr = 32'h6111_2222;
        cyc();
        a_instr = 32'h6333_4444;
        cyc();
        a_valid = 1'b0;
        cyc();
        chk("t5_in_hi", {16'b0, ctrlA}, 32'h0000_6111);
        #1 reset = 1'b1;
        #1;
        chk("t5_req", {31'b0, req}, 0);
        chk("t5_ctrlA", {16'b0, ctrlA}, 0);
        chk("t5_ctrlB", {16'b0, ctrlB}, 0);
        chk("t5_busy", {31'b0, busy}, 0);
        chk("t5_slot", {16'b0, slot_cnt}, 0);
        chk("t5_a_ready", {31'b0, a_ready}, 1);
        do_reset(2);
        ats_ready = 1'b1;
        repeat (12) begin
            cyc();
            chk("t5_no_req", {31'b0, req}, 0);
        end

        // slot_cnt wrap from 0xFFFF.
        force dut.slot_cnt_q = 16'hFFFF;
        #1 release dut.slot_cnt_q;
        exp_slot = 16'hFFFF;
        chk("t6_preload", {16'b0, slot_cnt}, 32'h0000_FFFF);
        a_valid = 1'b1;
        a_instr = 32'h7000_0001;
        cyc();
        a_valid = 1'b0;
        wait_idle(20);
        chk("t6_wrap", {16'b0, slot_cnt}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ats21_issue.md
# ats21_issue

Upstream instruction issuer for the ATS21 alarm/timer block. Buffers 32-bit instructions from two independent clients (A and B) in per-client FIFOs and serialises them onto the ATS21 command port. Each issue slot is a one-cycle `req`, then the upper 16 bits, then the lower 16 bits on `ctrlA`/`ctrlB`, then a two-cycle gap. A client with nothing queued is sent a NOP (opcode 000, all-zero word) in that slot.

## Interface
- `FIFO_DEPTH`, default 4: entries per client FIFO; power of two, at least 2.
- `clk` input, 1 bit: single clock; all state updates on the rising edge.
- `reset` input, 1 bit: asynchronous, active-high; clears all state.
- `a_valid` input, 1 bit: client A offers `a_instr`.
- `a_instr` input, 32 bits: client A instruction, [31:16] = first half, [15:0] = second half.
- `a_ready` output, 1 bit: FIFO A not full; push occurs on `a_valid && a_ready`.
- `b_valid`, `b_instr`, `b_ready`: same as the A ports, for client B.
- `ats_ready` input, 1 bit: ATS21 `ready`; a slot may only start while it is high.
- `req` output, 1 bit: to ATS21 `req`.
- `ctrlA` output, 16 bits: to ATS21 `ctrlA`.
- `ctrlB` output, 16 bits: to ATS21 `ctrlB`.
- `busy` output, 1 bit: FSM not in IDLE.
- `slot_cnt` output, 16 bits: number of issued slots; wraps from 0xFFFF to 0.

## Operation
- FSM states, in order: IDLE, REQ, HI, LO, GAP1, GAP2.
  - IDLE → REQ when `ats_ready` is high and either FIFO is non-empty. Otherwise stay in IDLE.
  - REQ → HI → LO → GAP1 → GAP2 → IDLE unconditionally.
  - `ats_ready` is sampled only in IDLE.
- On the IDLE→REQ edge, each non-empty FIFO pops its head into a holding register. An empty FIFO loads 32'h0000_0000 (NOP) instead. Both clients are always issued in the same slot.
- `slot_cnt` increments on the IDLE→REQ edge.
- Outputs are registered and driven by state:
  - `req` is 1 only in REQ.
  - In HI, `ctrlA`/`ctrlB` = holding register [31:16].
  - In LO, `ctrlA`/`ctrlB` = holding register [15:0].
  - In all other states `ctrlA`/`ctrlB` = 0.
- FIFO push and pop:
  - `a_ready` / `b_ready` = !full, combinational from the FIFO count.
  - A push and a pop on the same edge are both performed; the count is unchanged.
  - A push while full is refused (`ready` is low). No push is accepted when full, even if a pop is occurring on that edge.
- FIFO order is strict per client. Clients never reorder relative to themselves.
- Reset values: `req`=0, `ctrlA`=0, `ctrlB`=0, `busy`=0, `slot_cnt`=0, state IDLE, both FIFOs empty (`a_ready`=`b_ready`=1), holding registers 0.
- Reset mid-slot aborts the slot immediately. Outputs go to reset values asynchronously and the popped entries are lost.

## Timing
- Push accepted at edge k into an empty FIFO, with FSM in IDLE and `ats_ready`=1:
  - REQ entered at edge k+1, so `req` is high for one cycle.
  - HI at k+2, LO at k+3, GAP1/GAP2 at k+4/k+5, IDLE at k+6.
- A slot occupies 6 cycles including IDLE; back-to-back slots start every 6 cycles.
- `ats_ready` low in IDLE stalls indefinitely. Queued entries are held and pushes continue until full.
- Wrap-around: FIFO pointers wrap modulo `FIFO_DEPTH`, and `slot_cnt` wraps modulo 2^16.

## Structure
- Shared package `ats21_pkg`, holding:
  - state enum `issue_state_t`
  - opcode constants `OP_NOP`=3'b000, `OP_SET_CLK`=3'b001, `OP_EN_CLK`=3'b010, `OP_MODE`=3'b011, `OP_SET_ALARM`=3'b101, `OP_SET_TIMER`=3'b110, `OP_EN_ALARM`=3'b111
  - `NOP_INSTR` = 32'h0
- Sub-module `ats21_instr_fifo`:
  - synchronous single-clock FIFO, 32-bit data, parameter `DEPTH`
  - ports: push, pop, din, dout, full, empty
  - instantiated twice (A and B)
- FSM, holding registers, output registers and `slot_cnt` live in `ats21_issue`.

## Test plan
- Reset for 4 cycles, then A pushes 32'h2000_0000 (set clock 0, rate 0) and B is idle → `req` pulse, then `ctrlA`=16'h2000 and `ctrlB`=0, then `ctrlA`=0 and `ctrlB`=0; `slot_cnt`=1.
- A pushes 32'h2040_0000 and B pushes 32'h2240_0000 in the same cycle → one slot with `ctrlA`=16'h2040 and `ctrlB`=16'h2240 in HI.
- A pushes 5 instructions back-to-back with `ats_ready`=0 → 4 accepted, `a_ready` low on the 5th. Raise `ats_ready` → 4 slots at 6-cycle spacing, in push order.
- Full FIFO while the FSM pops on the IDLE→REQ edge → `a_ready` rises the following cycle, and the next push is accepted exactly once.
- Assert `reset` during HI → `ctrlA`/`ctrlB`/`req` go to 0 asynchronously, `busy`=0, FIFOs empty, `slot_cnt`=0.
- Preload `slot_cnt` to 0xFFFF via 65535 slots (or a force) → next slot wraps it to 0.
